lfsr_rng: RTL and testbench

Parametrised Fibonacci LFSR random-number generator. It is the successor to the fixed 8-bit runtime-tap LFSR. It adds:
- configurable state and output widths;
- seed load and free-run stirring;
- a request/valid draw handshake with range limiting by rejection sampling;
- all-zero lockup recovery.

Game logic uses it for event rolls, for example "pick 0..limit-1".

---
 rtl/lfsr_rng.sv | 150 +++++++++++++++
 tb/tb_lfsr_rng.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Parametrised Fibonacci LFSR random-number generator.
// Seed load, free-run stirring, req/valid draws with rejection sampling.
module lfsr_rng #(
    parameter int               WIDTH        = 16,
    parameter int               OUT_W        = 8,
    parameter int               STEPS        = 8,
    parameter int               MAX_RETRY    = 3,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [WIDTH-1:0] in_taps,
    input  logic [WIDTH-1:0] in_seed,
    input  logic             in_seed_load,
    input  logic             in_enable,
    input  logic             in_req,
    input  logic [OUT_W-1:0] in_limit,
    output logic [OUT_W-1:0] out_value,
    output logic             out_valid,
    output logic             out_busy,
    output logic             out_fallback,
    output logic             out_lockup
);

    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_CHECK
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             fallback_q, fallback_d;
    logic             lockup_q, lockup_d;

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [OUT_W-1:0] cand;
    logic             cand_ok;
    logic             unused_tap_msb;

    // The top tap bit has no state bit above it to select.
    assign unused_tap_msb = in_taps[WIDTH-1];

    // Feedback: bit 0 always, plus each state bit j selected by tap WIDTH-1-j.
    always_comb begin
        fb = lfsr_q[0];
        for (int j = 1; j < WIDTH; j++) begin
            fb = fb ^ (in_taps[WIDTH-1-j] & lfsr_q[j]);
        end
        shifted = {fb, lfsr_q[WIDTH-1:1]};
        cand    = lfsr_q[OUT_W-1:0];
        cand_ok = (in_limit == '0) || (cand < in_limit);
    end

    // Next-state: seed load beats lockup recovery beats the draw FSM.
    always_comb begin
        fsm_d      = fsm_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        value_d    = value_q;
        fallback_d = fallback_q;
        valid_d    = 1'b0;
        lockup_d   = 1'b0;
        if (in_seed_load) begin
            lfsr_d = in_seed;
            fsm_d  = ST_IDLE;
        end else if (lfsr_q == '0) begin
            lfsr_d   = DEFAULT_SEED;
            lockup_d = 1'b1;
        end else begin
            unique case (fsm_q)
                ST_IDLE: begin
                    if (in_req) begin
                        fsm_d   = ST_DRAW;
                        cnt_d   = CNT_W'(STEPS);
                        retry_d = '0;
                    end else if (in_enable) begin
                        lfsr_d = shifted;
                    end
                end
                ST_DRAW: begin
                    lfsr_d = shifted;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        fsm_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cand_ok) begin
                        value_d    = cand;
                        fallback_d = 1'b0;
                        valid_d    = 1'b1;
                        fsm_d      = ST_IDLE;
                    end else if (retry_q == RTY_W'(MAX_RETRY)) begin
                        value_d    = '0;
                        fallback_d = 1'b1;
                        valid_d    = 1'b1;
                        fsm_d      = ST_IDLE;
                    end else begin
                        retry_d = retry_q + RTY_W'(1);
                        cnt_d   = CNT_W'(STEPS);
                        fsm_d   = ST_DRAW;
                    end
                end
                default: begin
                    fsm_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            fsm_q      <= ST_IDLE;
            lfsr_q     <= DEFAULT_SEED;
            cnt_q      <= '0;
            retry_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            fallback_q <= 1'b0;
            lockup_q   <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            fallback_q <= fallback_d;
            lockup_q   <= lockup_d;
        end
    end

    assign out_value    = value_q;
    assign out_valid    = valid_q;
    assign out_busy     = (fsm_q != ST_IDLE);
    assign out_fallback = fallback_q;
    assign out_lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed testbench for lfsr_rng.
// 8-bit instance for draws; 4-bit instance for the period check.
module tb_lfsr_rng;

    logic       clk;
    logic       rst;
    logic [7:0] taps, seed, limit, value;
    logic       seed_load, enable, req;
    logic       valid, busy, fallback, lockup;

    logic [3:0] p_taps, p_seed, p_limit, p_value;
    logic       p_load, p_en, p_req;
    logic       p_valid, p_busy, p_fallback, p_lockup;

    int n_chk = 0;
    int n_err = 0;

    // Hand-derived sequence for fb = s0 ^ s1 starting from 0x1.
    localparam logic [3:0] PER [15] = '{
        4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
        4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1
    };

    lfsr_rng #(
        .WIDTH(8), .OUT_W(8), .STEPS(8), .MAX_RETRY(3),
        .DEFAULT_SEED(8'h01)
    ) dut (
        .in_clk(clk), .in_rst(rst), .in_taps(taps), .in_seed(seed),
        .in_seed_load(seed_load), .in_enable(enable), .in_req(req),
        .in_limit(limit), .out_value(value), .out_valid(valid),
        .out_busy(busy), .out_fallback(fallback), .out_lockup(lockup)
    );

    lfsr_rng #(
        .WIDTH(4), .OUT_W(4), .STEPS(1), .MAX_RETRY(0),
        .DEFAULT_SEED(4'h1)
    ) dut4 (
        .in_clk(clk), .in_rst(rst), .in_taps(p_taps), .in_seed(p_seed),
        .in_seed_load(p_load), .in_enable(p_en), .in_req(p_req),
        .in_limit(p_limit), .out_value(p_value), .out_valid(p_valid),
        .out_busy(p_busy), .out_fallback(p_fallback), .out_lockup(p_lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] s);
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    // Pulse a request, return edges from accept to out_valid.
    task automatic draw(output int n);
        req = 1'b1;
        tick();
        req = 1'b0;
        n   = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            n++;
            if (valid) break;
        end
        chk("draw_done", {31'd0, valid}, 32'd1);
    endtask

    initial begin
        int n, nv, gap;
        rst = 1'b1;
        taps = '0; seed = '0; limit = '0;
        seed_load = 1'b0; enable = 1'b0; req = 1'b0;
        p_taps = '0; p_seed = '0; p_limit = '0;
        p_load = 1'b0; p_en = 1'b0; p_req = 1'b0;
        #12;
        chk("rst_value", {24'd0, value}, 32'd0);
        chk("rst_flags", {28'd0, valid, busy, fallback, lockup}, 32'd0);
        chk("rst_state", {24'd0, dut.lfsr_q}, 32'h01);
        #1 rst = 1'b0;

        // Rotate with no taps, unbounded.
        load(8'h01);
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("acc_busy", {31'd0, busy}, 32'd1);
        chk("acc_noshift", {24'd0, dut.lfsr_q}, 32'h01);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rot_state", {24'd0, dut.lfsr_q}, 32'h0000_0100 >> i);
            chk("rot_novalid", {31'd0, valid}, 32'd0);
        end
        tick();
        chk("rot_valid", {31'd0, valid}, 32'd1);
        chk("rot_value", {24'd0, value}, 32'h01);
        chk("rot_fb", {31'd0, fallback}, 32'd0);
        chk("rot_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("rot_pulse", {31'd0, valid}, 32'd0);
        chk("rot_hold", {24'd0, value}, 32'h01);

        // Always-rejected candidate falls back after 4 attempts.
        load(8'h05);
        limit = 8'd4;
        draw(n);
        chk("fb_lat", n, 32'd36);
        chk("fb_value", {24'd0, value}, 32'd0);
        chk("fb_flag", {31'd0, fallback}, 32'd1);

        // cand == limit is out of range.
        load(8'h05);
        limit = 8'd5;
        draw(n);
        chk("lim_eq_lat", n, 32'd36);
        chk("lim_eq_fb", {31'd0, fallback}, 32'd1);

        // cand == limit-1 is accepted, fallback clears.
        load(8'h05);
        limit = 8'd6;
        draw(n);
        chk("lim_ok_lat", n, 32'd9);
        chk("lim_ok_value", {24'd0, value}, 32'h05);
        chk("lim_ok_fb", {31'd0, fallback}, 32'd0);
        limit = 8'd0;

        // Zero seed is replaced; concurrent request ignored.
        load(8'h00);
        chk("lk_zero", {24'd0, dut.lfsr_q}, 32'd0);
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("lk_state", {24'd0, dut.lfsr_q}, 32'h01);
        chk("lk_pulse", {31'd0, lockup}, 32'd1);
        chk("lk_nobusy", {31'd0, busy}, 32'd0);
        tick();
        chk("lk_once", {31'd0, lockup}, 32'd0);
        chk("lk_idle", {31'd0, busy}, 32'd0);

        // Seed load mid-draw aborts it.
        load(8'h01);
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (3) tick();
        chk("ab_mid", {24'd0, dut.lfsr_q}, 32'h20);
        load(8'h33);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_valid", {31'd0, valid}, 32'd0);
        chk("ab_state", {24'd0, dut.lfsr_q}, 32'h33);
        chk("ab_value", {24'd0, value}, 32'h05);
        nv = 0;
        repeat (12) begin
            tick();
            if (valid) nv++;
        end
        chk("ab_noval", nv, 32'd0);

        // Reset while in CHECK.
        load(8'h01);
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (8) tick();
        chk("rs_busy", {31'd0, busy}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("rs_value", {24'd0, value}, 32'd0);
        chk("rs_flags", {28'd0, valid, busy, fallback, lockup}, 32'd0);
        chk("rs_state", {24'd0, dut.lfsr_q}, 32'h01);
        #1 rst = 1'b0;

        // Requests during DRAW and CHECK are dropped.
        req = 1'b1;
        tick();
        nv = 0;
        for (int e = 1; e <= 30; e++) begin
            req = (e == 3 || e == 4 || e == 9);
            tick();
            if (valid) nv++;
        end
        req = 1'b0;
        chk("busy_one", nv, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // Held request: accept lands in the valid cycle, so
        // pulses are STEPS+1 plus that one accept edge apart.
        load(8'h01);
        req = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (valid) break;
        end
        chk("b2b_first", {31'd0, valid}, 32'd1);
        chk("b2b_v1", {24'd0, value}, 32'h01);
        gap = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            gap++;
            if (valid) break;
        end
        chk("b2b_gap", gap, 32'd10);
        chk("b2b_v2", {24'd0, value}, 32'h01);
        req = 1'b0;
        repeat (15) tick();

        // 4-bit maximal-length period.
        p_taps = 4'b0100;
        p_seed = 4'h1;
        p_load = 1'b1;
        tick();
        p_load = 1'b0;
        p_en   = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("period", {28'd0, dut4.lfsr_q}, {28'd0, PER[i]});
        end
        p_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
